// File: rtl/camera_reset_seq.sv
// Camera reset sequencer with an Avalon-MM register slave.
// A START command drives camera_reset_n low for ASSERT cycles, then waits
// SETTLE cycles before flagging cam_ready/DONE. Register values of zero are
// treated as one so the sequence always makes progress.
//
//   state  | meaning
//   -------+------------------------------------------------
//   IDLE   | no sequence running, camera out of reset
//   ASSERT | camera_reset_n held low, counting ASSERT cycles
//   SETTLE | camera_reset_n released, counting SETTLE cycles
//   READY  | sequence complete, cam_ready high
module camera_reset_seq #(
    parameter int CNT_W      = 24,
    parameter int DEF_ASSERT = 5000,
    parameter int DEF_SETTLE = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        camera_reset_n,
    output logic        cam_ready,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_SETTLE = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] reg_assert;
    logic [CNT_W-1:0] reg_settle;
    logic             done;
    logic             irq_en;

    logic             wr_en;
    logic             ctrl_wr;
    logic             start;
    logic             done_clr;
    logic             abort;
    logic             busy;
    logic [CNT_W-1:0] load_assert;
    logic [CNT_W-1:0] load_settle;
    logic             unused_wdata;

    assign wr_en       = chipselect & ~write_n;
    assign ctrl_wr     = wr_en & (address == 2'd0);
    assign start       = ctrl_wr & writedata[0];
    assign done_clr    = ctrl_wr & writedata[2];
    assign abort       = ctrl_wr & writedata[3];
    assign busy        = (state == ST_ASSERT) || (state == ST_SETTLE);
    assign load_assert = (reg_assert == '0) ? ONE : reg_assert;
    assign load_settle = (reg_settle == '0) ? ONE : reg_settle;
    assign unused_wdata = ^writedata;

    // Configuration registers; timing writes land immediately but are only
    // consumed at the next counter load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_assert <= CNT_W'(DEF_ASSERT);
            reg_settle <= CNT_W'(DEF_SETTLE);
            irq_en     <= 1'b0;
        end else if (wr_en) begin
            case (address)
                2'd0:    irq_en     <= writedata[1];
                2'd1:    reg_assert <= writedata[CNT_W-1:0];
                2'd2:    reg_settle <= writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // Sequencer FSM with down-counter and registered camera outputs.
    // DONE_CLR is applied first so a same-edge DONE set overrides it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            camera_reset_n <= 1'b1;
            cam_ready      <= 1'b0;
            done           <= 1'b0;
        end else begin
            if (done_clr) begin
                done <= 1'b0;
            end
            if (abort) begin
                state          <= ST_IDLE;
                cnt            <= '0;
                camera_reset_n <= 1'b1;
                cam_ready      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_READY: begin
                        if (start) begin
                            state          <= ST_ASSERT;
                            cnt            <= load_assert;
                            camera_reset_n <= 1'b0;
                            cam_ready      <= 1'b0;
                            done           <= 1'b0;
                        end
                    end
                    ST_ASSERT: begin
                        if (cnt <= ONE) begin
                            state          <= ST_SETTLE;
                            cnt            <= load_settle;
                            camera_reset_n <= 1'b1;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt <= ONE) begin
                            state     <= ST_READY;
                            cnt       <= '0;
                            cam_ready <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // Level interrupt, registered from DONE gated by the enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= done & irq_en;
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[4:0]       = {state, done, irq_en, busy};
            2'd1:    readdata[CNT_W-1:0] = reg_assert;
            2'd2:    readdata[CNT_W-1:0] = reg_settle;
            default: readdata[CNT_W-1:0] = cnt;
        endcase
    end

endmodule
